// File: rtl/axsub_pkg.sv
// Shared types for the digit-serial approximate subtractor: cell mode and
// controller state encodings, plus a decoder that folds the reserved mode onto EXACT.
package axsub_pkg;

    typedef enum logic [1:0] {
        EXACT = 2'd0,
        AX1   = 2'd1,
        AX2   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return AX1;
            2'd2:    return AX2;
            default: return EXACT;
        endcase
    endfunction

endpackage

// File: rtl/axsub_cell.sv
// One-bit subtractor cell: exact full subtractor, or one of the two
// approximate variants when approx is set.
import axsub_pkg::*;

module axsub_cell (
    input  logic  x,
    input  logic  y,
    input  logic  bin,
    input  logic  approx,
    input  mode_e mode,
    output logic  diff,
    output logic  bout
);

    logic t;
    assign t = x ^ y;

    always_comb begin
        diff = t ^ bin;
        bout = t ? y : bin;
        if (approx) begin
            case (mode)
                AX1:     diff = t | bin;
                AX2:     bout = t ^ bin;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axsub_ds.sv
// Digit-serial W-bit subtractor with a configurable number of approximate LSBs.
// One D-bit digit is resolved per BUSY cycle; the result is held until out_ready.
import axsub_pkg::*;

module axsub_ds #(
    parameter int W  = 16,
    parameter int D  = 4,
    parameter int KW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          bin,
    input  logic [1:0]    mode,
    input  logic [KW-1:0] k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  diff,
    output logic          bout
);

    localparam int N  = W / D;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    generate
        if ((D > W) || ((W % D) != 0)) begin : g_bad_param
            $error("axsub_ds: W must be a non-zero multiple of D with D <= W");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, b_q, diff_q;
    mode_e         mode_q;
    logic [KW-1:0] k_eff_q;
    logic          borrow_q, bout_q;
    logic [JW-1:0] digit_q;

    logic          accept, last_digit;
    logic [KW-1:0] k_eff;
    logic [BW-1:0] base;
    logic [D-1:0]  a_dig, b_dig, dig_diff, approx;
    logic [D:0]    chain;

    assign k_eff = (32'(k) > 32'(W)) ? KW'(W) : k;

    // Bit position of the current digit's LSB; selects operand slices and the cell mask.
    assign base       = BW'(digit_q) * BW'(D);
    assign last_digit = (digit_q == JW'(N - 1));
    assign a_dig      = a_q[base +: D];
    assign b_dig      = b_q[base +: D];
    assign chain[0]   = borrow_q;

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_cell
            assign approx[gi] = (32'(base) + 32'(gi)) < 32'(k_eff_q);

            axsub_cell u_cell (
                .x      (a_dig[gi]),
                .y      (b_dig[gi]),
                .bin    (chain[gi]),
                .approx (approx[gi]),
                .mode   (mode_q),
                .diff   (dig_diff[gi]),
                .bout   (chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= EXACT;
            k_eff_q  <= '0;
            borrow_q <= 1'b0;
            digit_q  <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                mode_q   <= decode_mode(mode);
                k_eff_q  <= k_eff;
                borrow_q <= bin;
                digit_q  <= '0;
            end else if (state_q == BUSY) begin
                diff_q[base +: D] <= dig_diff;
                borrow_q          <= chain[D];
                if (last_digit) begin
                    bout_q  <= chain[D];
                    digit_q <= '0;
                end else begin
                    digit_q <= digit_q + JW'(1);
                end
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_axsub_ds.sv
// Directed and randomized checks of axsub_ds (W=16, D=4) against a bitwise
// arithmetic reference model of the subtractor cells.
module tb_axsub_ds;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [15:0] a, b, diff;
    logic [1:0]  mode;
    logic [4:0]  k;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    axsub_ds #(.W(16), .D(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .mode      (mode),
        .k         (k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    // Returns {bout, diff}; each bit is an arithmetic 1-bit subtraction, modified per cell rules.
    function automatic logic [16:0] ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                              input logic rbin, input logic [1:0] rmode,
                                              input logic [4:0] rk);
        logic [16:0] r;
        int kk, br, x, y, s, d, nb, m;
        kk = (int'(rk) > 16) ? 16 : int'(rk);
        br = int'(rbin);
        r  = '0;
        for (int i = 0; i < 16; i++) begin
            x  = int'(ra[i]);
            y  = int'(rb[i]);
            s  = x - y - br;
            d  = s & 1;
            nb = (s < 0) ? 1 : 0;
            m  = (i < kk) ? int'(rmode) : 0;
            if (m == 1) d = ((x != y) || (br != 0)) ? 1 : 0;
            else if (m == 2) nb = d;
            r[i] = d[0];
            br   = nb;
        end
        r[16] = br[0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                         input logic [1:0] tmode, input logic [4:0] tk, output int lat);
        a = ta; b = tb_; bin = tbin; mode = tmode; k = tk; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the in-flight result must not change.
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        mode = 2'($urandom); k = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic op_check(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic tbin, input logic [1:0] tmode, input logic [4:0] tk,
                            input logic [15:0] exp_d, input logic exp_b);
        int lat;
        issue(ta, tb_, tbin, tmode, tk, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_b));
        $display("op %s a=%h b=%h bin=%0d mode=%0d k=%0d -> diff=%h bout=%0d lat=%0d",
                 tag, ta, tb_, tbin, tmode, tk, diff, bout, lat);
        consume(tag);
    endtask

    initial begin
        logic [16:0] exp;
        logic [16:0] arith;
        logic [15:0] ra, rb;
        logic        rbin, seen;
        logic [1:0]  rmode;
        logic [4:0]  rk;
        int          lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0; mode = 2'd0; k = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_bout", 32'(bout), 32'd0);

        op_check("exact_basic", 16'h1234, 16'h0235, 1'b0, 2'd0, 5'd16, 16'h0FFF, 1'b0);
        op_check("exact_neg", 16'h0000, 16'h0001, 1'b0, 2'd0, 5'd16, 16'hFFFF, 1'b1);
        op_check("ax1_k0", 16'h0000, 16'h0001, 1'b0, 2'd1, 5'd0, 16'hFFFF, 1'b1);
        op_check("ax1_k4", 16'h0002, 16'h0001, 1'b0, 2'd1, 5'd4, 16'h0003, 1'b0);
        op_check("ax2_k4_a", 16'h0001, 16'h0000, 1'b0, 2'd2, 5'd4, 16'hFFFF, 1'b1);
        op_check("ax2_k4_b", 16'h0002, 16'h0001, 1'b0, 2'd2, 5'd4, 16'h0001, 1'b0);

        ra = 16'($urandom); rb = 16'($urandom);
        exp = ref_model(ra, rb, 1'b1, 2'd1, 5'd17);
        op_check("ax1_k17_clamp", ra, rb, 1'b1, 2'd1, 5'd17, exp[15:0], exp[16]);

        // Reserved mode with every bit approximate must still be exact subtraction.
        ra = 16'($urandom); rb = 16'($urandom);
        arith = {1'b0, ra} - {1'b0, rb} - 17'd1;
        op_check("mode3_exact", ra, rb, 1'b1, 2'd3, 5'd31, arith[15:0], arith[16]);

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            rmode = 2'($urandom); rk = 5'($urandom);
            exp = ref_model(ra, rb, rbin, rmode, rk);
            op_check($sformatf("rand%0d", i), ra, rb, rbin, rmode, rk, exp[15:0], exp[16]);
        end

        // Backpressure: result held, in_valid ignored while DONE.
        exp = ref_model(16'h5A5A, 16'h1234, 1'b1, 2'd1, 5'd6);
        issue(16'h5A5A, 16'h1234, 1'b1, 2'd1, 5'd6, lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; mode = 2'd0; k = 5'd0;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("bp_diff_c%0d", c), 32'(diff), 32'(exp[15:0]));
            chk($sformatf("bp_bout_c%0d", c), 32'(bout), 32'(exp[16]));
            chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp_out_valid_c%0d", c), 32'(out_valid), 32'd1);
        end
        $display("op backpressure diff=%h bout=%0d held 5 cycles", diff, bout);
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp_no_accept_on_release", 32'(in_ready), 32'd1);

        // Reset in the second BUSY cycle aborts the operation.
        a = 16'hABCD; b = 16'h1111; bin = 1'b0; mode = 2'd0; k = 5'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", 32'(seen), 32'd0);
        $display("op reset-abort in_ready=%0d diff=%h", in_ready, diff);
        op_check("after_abort", 16'h1234, 16'h0235, 1'b0, 2'd0, 5'd16, 16'h0FFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
